// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter that shares the memory's single write port and read
//   port 0 among NREQ requesters. One transaction is in flight at a time: the
//   winner's request is forwarded over the memory's level req/ack handshake,
//   and completion is reported back as a one-cycle c_ack pulse with read data
//   and an error flag. Every access is bounded by TIMEOUT cycles so a stalled
//   memory cannot hang a requester.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   c_req / c_we        per-requester request level and write enable
//   c_addr / c_wdata    packed per-requester address / write data
//   c_ack               one-hot completion pulse (one cycle)
//   c_rdata / c_err     read data and error (permission or timeout), valid with c_ack
//   busy                high whenever a transaction is in progress
//   gnt_id              index of current / last granted requester
//   m_rreq/m_raddr/m_rdata/m_rack   memory read port handshake
//   m_wreq/m_waddr/m_wdata/m_wack   memory write port handshake
//   m_werr              memory write-protect error, sampled with m_wack
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int NREQ       = 3,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               c_req,
    input  logic [NREQ-1:0]               c_we,
    input  logic [NREQ*ADDR_WIDTH-1:0]    c_addr,
    input  logic [NREQ*DATA_WIDTH-1:0]    c_wdata,
    output logic [NREQ-1:0]               c_ack,
    output logic [DATA_WIDTH-1:0]         c_rdata,
    output logic                          c_err,
    output logic                          busy,
    output logic [$clog2(NREQ)-1:0]       gnt_id,
    output logic                          m_rreq,
    output logic [ADDR_WIDTH-1:0]         m_raddr,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_rack,
    output logic                          m_wreq,
    output logic [ADDR_WIDTH-1:0]         m_waddr,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    input  logic                          m_wack,
    input  logic                          m_werr
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // First set request bit searching ptr, ptr+1, ... wrapping at NREQ-1.
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [GW-1:0]   ptr);
        logic [GW-1:0] pick;
        logic [GW:0]   idx;
        logic          found;
        logic          hit;
        pick  = ptr;
        found = 1'b0;
        for (int k = 32'sd0; k < NREQ; k++) begin
            idx   = {1'b0, ptr} + (GW+1)'(k);
            idx   = (idx >= (GW+1)'(NREQ)) ? (idx - (GW+1)'(NREQ)) : idx;
            hit   = !found && req[idx[GW-1:0]];
            pick  = hit ? idx[GW-1:0] : pick;
            found = found | hit;
        end
        return pick;
    endfunction

    logic [1:0]            state_r,  state_s;
    logic [GW-1:0]         ptr_r,    ptr_s;
    logic [GW-1:0]         gnt_r,    gnt_s;
    logic [TW-1:0]         tcnt_r,   tcnt_s;
    logic                  we_r,     we_s;
    logic [NREQ-1:0]       ack_r,    ack_s;
    logic [DATA_WIDTH-1:0] rdata_r,  rdata_s;
    logic                  err_r,    err_s;
    logic                  busy_r,   busy_s;
    logic                  rreq_r,   rreq_s;
    logic                  wreq_r,   wreq_s;
    logic [ADDR_WIDTH-1:0] raddr_r,  raddr_s;
    logic [ADDR_WIDTH-1:0] waddr_r,  waddr_s;
    logic [DATA_WIDTH-1:0] wdata_r,  wdata_s;
    logic [GW-1:0]         pick_s;
    logic                  sel_ack_s;

    assign pick_s    = rr_pick(c_req, ptr_r);
    // Only the port actually used by the granted transaction is listened to.
    assign sel_ack_s = we_r ? m_wack : m_rack;

    // Next-state and next-output computation for the IDLE/ISSUE/DRAIN sequence.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        gnt_s   = gnt_r;
        tcnt_s  = tcnt_r;
        we_s    = we_r;
        ack_s   = '0;
        rdata_s = rdata_r;
        err_s   = err_r;
        rreq_s  = rreq_r;
        wreq_s  = wreq_r;
        raddr_s = raddr_r;
        waddr_s = waddr_r;
        wdata_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (|c_req) begin
                    gnt_s  = pick_s;
                    we_s   = c_we[pick_s];
                    tcnt_s = '0;
                    if (c_we[pick_s]) begin
                        wreq_s  = 1'b1;
                        rreq_s  = 1'b0;
                        waddr_s = c_addr[pick_s*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_s = c_wdata[pick_s*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        rreq_s  = 1'b1;
                        wreq_s  = 1'b0;
                        raddr_s = c_addr[pick_s*ADDR_WIDTH +: ADDR_WIDTH];
                    end
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (sel_ack_s) begin
                    // A real ack beats a timeout landing on the same edge.
                    rreq_s        = 1'b0;
                    wreq_s        = 1'b0;
                    ack_s[gnt_r]  = 1'b1;
                    rdata_s       = we_r ? '0 : m_rdata;
                    err_s         = we_r ? m_werr : 1'b0;
                    state_s       = ST_DRAIN;
                end else if (tcnt_r == TW'(TIMEOUT - 1)) begin
                    rreq_s        = 1'b0;
                    wreq_s        = 1'b0;
                    ack_s[gnt_r]  = 1'b1;
                    rdata_s       = '0;
                    err_s         = 1'b1;
                    tcnt_s        = tcnt_r + 1'b1;
                    state_s       = ST_DRAIN;
                end else begin
                    tcnt_s        = tcnt_r + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Wait for the memory to drop its ack so the next grant starts clean.
                if (!sel_ack_s) begin
                    ptr_s   = (gnt_r == GW'(NREQ - 1)) ? '0 : (gnt_r + 1'b1);
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                rreq_s  = 1'b0;
                wreq_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset also drops the memory requests immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            gnt_r   <= '0;
            tcnt_r  <= '0;
            we_r    <= 1'b0;
            ack_r   <= '0;
            rdata_r <= '0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            rreq_r  <= 1'b0;
            wreq_r  <= 1'b0;
            raddr_r <= '0;
            waddr_r <= '0;
            wdata_r <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            gnt_r   <= gnt_s;
            tcnt_r  <= tcnt_s;
            we_r    <= we_s;
            ack_r   <= ack_s;
            rdata_r <= rdata_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
            rreq_r  <= rreq_s;
            wreq_r  <= wreq_s;
            raddr_r <= raddr_s;
            waddr_r <= waddr_s;
            wdata_r <= wdata_s;
        end
    end

    assign c_ack   = ack_r;
    assign c_rdata = rdata_r;
    assign c_err   = err_r;
    assign busy    = busy_r;
    assign gnt_id  = gnt_r;
    assign m_rreq  = rreq_r;
    assign m_raddr = raddr_r;
    assign m_wreq  = wreq_r;
    assign m_waddr = waddr_r;
    assign m_wdata = wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Expected completions are queued as
//   each scenario is set up; a monitor pops and compares whenever c_ack fires.
//   A registered memory model (address 0 write-protected, optional stall)
//   answers the read and write ports.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NREQ = 3;

    logic        clk;
    logic        rst;
    logic [2:0]  c_req;
    logic [2:0]  c_we;
    logic [47:0] c_addr;
    logic [47:0] c_wdata;
    logic [2:0]  c_ack;
    logic [15:0] c_rdata;
    logic        c_err;
    logic        busy;
    logic [1:0]  gnt_id;
    logic        m_rreq;
    logic [15:0] m_raddr;
    bit   [15:0] m_rdata;
    bit          m_rack;
    logic        m_wreq;
    logic [15:0] m_waddr;
    logic [15:0] m_wdata;
    bit          m_wack;
    bit          m_werr;

    bit          stall;
    bit   [15:0] mem   [256];
    bit          wrote [256];

    typedef struct {
        int          id;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   issued[NREQ];
    int   done[NREQ];
    int   errors = 0;
    int   checks = 0;
    int   both_cnt = 0;

    mem_port_arbiter #(.NREQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err), .busy(busy), .gnt_id(gnt_id),
        .m_rreq(m_rreq), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rack(m_rack),
        .m_wreq(m_wreq), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wack(m_wack),
        .m_werr(m_werr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {8'hA5, a};
    endfunction

    // Registered memory: ack follows req by one edge unless stalled; address 0 is read-only.
    always @(posedge clk) begin
        m_rack  <= m_rreq && !stall;
        m_wack  <= m_wreq && !stall;
        m_rdata <= wrote[m_raddr[7:0]] ? mem[m_raddr[7:0]] : init_val(m_raddr[7:0]);
        m_werr  <= (m_waddr == 16'h0000);
        if (m_wreq && !stall && m_waddr != 16'h0000) begin
            mem[m_waddr[7:0]]   <= m_wdata;
            wrote[m_waddr[7:0]] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input int id, input logic [15:0] rdata, input logic err);
        exp_t e;
        e.id    = id;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic issue(input int id, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd, input int n);
        c_we[id]            = we;
        c_addr[id*16 +: 16] = addr;
        c_wdata[id*16 +: 16] = wd;
        issued[id]          += n;
    endtask

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < NREQ; i++) p += issued[i] - done[i];
        return p;
    endfunction

    task automatic wait_all(input string name);
        int n = 0;
        @(posedge clk); #1;
        while ((sb.size() != 0 || pending() != 0 || busy !== 1'b0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(n < 400), 32'd1);
    endtask

    // Requesters: hold c_req while work is outstanding, drop it during the c_ack cycle.
    initial begin
        c_req = 3'b000;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (c_ack[i] === 1'b1) done[i]++;
                c_req[i] = (issued[i] > done[i]) && (c_ack[i] !== 1'b1);
            end
        end
    end

    // Monitor: compare every completion against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_rreq === 1'b1 && m_wreq === 1'b1) both_cnt++;
            if (c_ack !== 3'b000) begin
                check("ack_onehot", 32'($onehot(c_ack)), 32'd1);
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(c_ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_id", 32'(c_ack), 32'(3'b001 << e.id));
                    check("ack_gnt_id", 32'(gnt_id), 32'(e.id));
                    check("ack_rdata", 32'(c_rdata), 32'(e.rdata));
                    check("ack_err", 32'(c_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cnt;
        rst     = 1'b1;
        stall   = 1'b0;
        c_we    = 3'b000;
        c_addr  = '0;
        c_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_ack", 32'(c_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_m_rreq", 32'(m_rreq), 32'd0);
        check("rst_m_wreq", 32'(m_wreq), 32'd0);
        check("rst_c_rdata", 32'(c_rdata), 32'd0);
        check("rst_c_err", 32'(c_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single read of 0x0010 by requester 0, with latency checks.
        expect_ack(0, 16'hBEEF, 1'b0);
        issue(0, 1'b0, 16'h0010, 16'h0000, 1);
        @(posedge clk); #1;
        check("t1_m_rreq", 32'(m_rreq), 32'd1);
        check("t1_m_wreq", 32'(m_wreq), 32'd0);
        check("t1_m_raddr", 32'(m_raddr), 32'h0010);
        check("t1_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clk); #1;
        check("t1_c_ack", 32'(c_ack), 32'd1);
        repeat (2) @(posedge clk); #1;
        check("t1_busy_fall", 32'(busy), 32'd0);
        wait_all("t1_done");

        // Write to protected address 0 by requester 2 (ptr is 1, so 2 wins).
        expect_ack(2, 16'h0000, 1'b1);
        issue(2, 1'b1, 16'h0000, 16'h1234, 1);
        @(posedge clk); #1;
        check("t3_m_wreq", 32'(m_wreq), 32'd1);
        check("t3_m_wdata", 32'(m_wdata), 32'h1234);
        check("t3_gnt_id", 32'(gnt_id), 32'd2);
        wait_all("t3_done");

        // Fairness: all three request twice, ptr back at 0 -> 0,1,2,0,1,2.
        for (int r = 0; r < 2; r++) begin
            expect_ack(0, 16'hA520, 1'b0);
            expect_ack(1, 16'hA521, 1'b0);
            expect_ack(2, 16'hA522, 1'b0);
        end
        issue(0, 1'b0, 16'h0020, 16'h0000, 2);
        issue(1, 1'b0, 16'h0021, 16'h0000, 2);
        issue(2, 1'b0, 16'h0022, 16'h0000, 2);
        wait_all("t2_done");

        // Timeout: memory never acks a read by requester 1.
        stall = 1'b1;
        expect_ack(1, 16'h0000, 1'b1);
        issue(1, 1'b0, 16'h0050, 16'h0000, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_rreq !== 1'b1 && n < 20);
        cnt = 0;
        while (m_rreq === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t4_issue_cycles", 32'(cnt), 32'd15);
        check("t4_m_rreq_low", 32'(m_rreq), 32'd0);
        check("t4_c_ack", 32'(c_ack), 32'b010);
        @(posedge clk); #1;
        check("t4_busy_fall", 32'(busy), 32'd0);
        stall = 1'b0;
        wait_all("t4_done");

        // Requester 0 alone, leaving ptr at 1 before the reset test.
        expect_ack(0, 16'hA530, 1'b0);
        issue(0, 1'b0, 16'h0030, 16'h0000, 1);
        wait_all("t5_pre_done");

        // Reset in ISSUE: requester 1 stuck, then 0 and 1 both requesting.
        stall = 1'b1;
        issue(1, 1'b0, 16'h0031, 16'h0000, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (m_rreq !== 1'b1 && n < 20);
        check("t5_pre_gnt", 32'(gnt_id), 32'd1);
        issue(0, 1'b0, 16'h0032, 16'h0000, 1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_m_rreq", 32'(m_rreq), 32'd0);
        check("t5_rst_m_wreq", 32'(m_wreq), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_c_ack", 32'(c_ack), 32'd0);
        check("t5_rst_gnt_id", 32'(gnt_id), 32'd0);
        stall = 1'b0;
        expect_ack(0, 16'hA532, 1'b0);
        expect_ack(1, 16'hA531, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_all("t5_done");

        // Starvation: 0 writes repeatedly, 1 reads the same address once (ptr at 2).
        expect_ack(0, 16'h0000, 1'b0);
        expect_ack(1, 16'h5A5A, 1'b0);
        expect_ack(0, 16'h0000, 1'b0);
        expect_ack(0, 16'h0000, 1'b0);
        issue(0, 1'b1, 16'h0040, 16'h5A5A, 3);
        issue(1, 1'b0, 16'h0040, 16'h0000, 1);
        wait_all("t6_done");

        check("port_exclusive", 32'(both_cnt), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
